stream_max_finder: RTL and testbench

//  Frame-based running-maximum tracker. Accepts LEN samples over a valid/ready stream and

---
 rtl/stream_max_finder.sv | 160 ++++++++++++++++
 tb/tb_stream_max_finder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_max_finder.sv
// ---------------------------------------------------------------------------
// stream_max_finder
//
// Frame-based running-maximum tracker. A frame is started with iSTART while
// idle, then LEN samples are accepted over a valid/ready handshake. The block
// reports the largest sample (oMAX) and the index of its first occurrence
// (oIDX). Ordering is signed or unsigned, chosen once per frame at start time.
// The result is held with oVALID until iACK.
//
// Ports
//    iCLK     in   1     clock, rising edge
//    iRST_N   in   1     synchronous reset, active-low
//    iSTART   in   1     start-of-frame request (looked at only in IDLE)
//    iSIGNED  in   1     1 = two's-complement ordering, 0 = unsigned
//    iDATA    in   W     sample data
//    iVALID   in   1     iDATA valid
//    oREADY   out  1     sample can be accepted this cycle
//    oMAX     out  W     frame maximum (meaningful while oVALID=1)
//    oIDX     out  IDXW  index of the frame maximum
//    oVALID   out  1     result valid, held until iACK
//    iACK     in   1     result consumed
//    oBUSY    out  1     frame in progress or result pending
// ---------------------------------------------------------------------------

// Combinational greater-than comparator with selectable signed ordering.
module dual_comp #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         is_signed,
   output logic         a_gt_b
);

   // Strict greater-than under the requested ordering.
   always_comb begin
      if (is_signed) begin
         a_gt_b = $signed(a) > $signed(b);
      end else begin
         a_gt_b = a > b;
      end
   end

endmodule

module stream_max_finder #(
   parameter int W    = 8,
   parameter int LEN  = 16,
   parameter int IDXW = 4
) (
   input  logic            iCLK,
   input  logic            iRST_N,
   input  logic            iSTART,
   input  logic            iSIGNED,
   input  logic [W-1:0]    iDATA,
   input  logic            iVALID,
   output logic            oREADY,
   output logic [W-1:0]    oMAX,
   output logic [IDXW-1:0] oIDX,
   output logic            oVALID,
   input  logic            iACK,
   output logic            oBUSY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LEN - 1);

   state_t          state_q, state_d;
   logic [IDXW-1:0] count_q, count_d;
   logic            mode_q,  mode_d;
   logic [W-1:0]    max_q,   max_d;
   logic [IDXW-1:0] idx_q,   idx_d;
   logic            data_gt_max;

   // Compare the incoming sample against the running maximum using the
   // ordering latched when the frame started.
   dual_comp #(.W(W)) u_comp (
      .a         (iDATA),
      .b         (max_q),
      .is_signed (mode_q),
      .a_gt_b    (data_gt_max)
   );

   // Next-state and datapath logic. The first sample of a frame always loads
   // the maximum; later samples replace it only when strictly larger, so ties
   // keep the earliest index. The count stops at LEN-1 on the final accept,
   // which is why it never needs to wrap.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mode_d  = mode_q;
      max_d   = max_q;
      idx_d   = idx_q;

      case (state_q)
         IDLE: begin
            if (iSTART) begin
               mode_d  = iSIGNED;
               count_d = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            if (iVALID) begin
               if ((count_q == '0) || data_gt_max) begin
                  max_d = iDATA;
                  idx_d = count_q;
               end
               if (count_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  count_d = count_q + IDXW'(1);
               end
            end
         end

         DONE: begin
            if (iACK) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset; a reset mid-frame
   // throws away any partial result.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q <= IDLE;
         count_q <= '0;
         mode_q  <= 1'b0;
         max_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         max_q   <= max_d;
         idx_q   <= idx_d;
      end
   end

   // Every output is decoded from registered state only.
   assign oREADY = (state_q == RUN);
   assign oVALID = (state_q == DONE);
   assign oBUSY  = (state_q != IDLE);
   assign oMAX   = max_q;
   assign oIDX   = idx_q;

endmodule

// File: tb/tb_stream_max_finder.sv
// ---------------------------------------------------------------------------
// tb_stream_max_finder
//
// Self-checking bench for stream_max_finder with W=8, LEN=4. Inputs are
// driven and outputs observed on the falling clock edge. Directed scenarios
// use the known answers; randomized frames are checked against a reference
// model that simply scans the frame as integers.
// ---------------------------------------------------------------------------
module tb_stream_max_finder;

   localparam int W    = 8;
   localparam int LEN  = 4;
   localparam int IDXW = 2;

   logic            iCLK = 1'b0;
   logic            iRST_N;
   logic            iSTART;
   logic            iSIGNED;
   logic [W-1:0]    iDATA;
   logic            iVALID;
   logic            oREADY;
   logic [W-1:0]    oMAX;
   logic [IDXW-1:0] oIDX;
   logic            oVALID;
   logic            iACK;
   logic            oBUSY;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] frame_data [LEN];

   stream_max_finder #(.W(W), .LEN(LEN), .IDXW(IDXW)) dut (
      .iCLK    (iCLK),
      .iRST_N  (iRST_N),
      .iSTART  (iSTART),
      .iSIGNED (iSIGNED),
      .iDATA   (iDATA),
      .iVALID  (iVALID),
      .oREADY  (oREADY),
      .oMAX    (oMAX),
      .oIDX    (oIDX),
      .oVALID  (oVALID),
      .iACK    (iACK),
      .oBUSY   (oBUSY)
   );

   // 10 ns clock.
   always #5 iCLK = ~iCLK;

   // Global time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   // Numeric value of a sample under the chosen ordering.
   function automatic int sample_value(input logic m, input logic [W-1:0] x);
      int v;
      v = int'(x);
      if (m && v >= 128) v = v - 256;
      return v;
   endfunction

   // Reference: first index holding the largest value in frame_data.
   task automatic model(input logic m, output logic [W-1:0] mx, output logic [IDXW-1:0] ix);
      int best;
      int best_i;
      best   = sample_value(m, frame_data[0]);
      best_i = 0;
      for (int i = 1; i < LEN; i++) begin
         if (sample_value(m, frame_data[i]) > best) begin
            best   = sample_value(m, frame_data[i]);
            best_i = i;
         end
      end
      mx = frame_data[best_i];
      ix = IDXW'(best_i);
   endtask

   task automatic tick();
      @(negedge iCLK);
   endtask

   // Issue a start request from IDLE; returns with the DUT in RUN.
   task automatic start_frame(input logic m);
      iSTART  = 1'b1;
      iSIGNED = m;
      tick();
      iSTART  = 1'b0;
      iSIGNED = 1'($urandom);
   endtask

   // Present one sample for one cycle, then leave iVALID low for gap cycles
   // with junk on iDATA.
   task automatic feed(input logic [W-1:0] d, input int gap);
      iVALID = 1'b1;
      iDATA  = d;
      tick();
      iVALID = 1'b0;
      iDATA  = W'($urandom);
      repeat (gap) tick();
   endtask

   task automatic test_reset();
      iRST_N = 1'b0;
      tick();
      tick();
      checks++; if (oREADY !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", oREADY); end
      checks++; if (oVALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", oVALID); end
      checks++; if (oBUSY  !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", oBUSY); end
      checks++; if (oMAX   !== 8'h00) begin errors++; $display("[TB] FAIL reset_max got %h want 00", oMAX); end
      checks++; if (oIDX   !== 2'd0) begin errors++; $display("[TB] FAIL reset_idx got %0d want 0", oIDX); end
      iRST_N = 1'b1;
      tick();
      checks++; if (oBUSY !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b want 0", oBUSY); end
   endtask

   task automatic test_unsigned();
      start_frame(1'b0);
      checks++; if (oREADY !== 1'b1) begin errors++; $display("[TB] FAIL run_ready got %b want 1", oREADY); end
      checks++; if (oBUSY !== 1'b1) begin errors++; $display("[TB] FAIL run_busy got %b want 1", oBUSY); end
      feed(8'h10, 0);
      feed(8'hF0, 0);
      feed(8'h7F, 0);
      checks++; if (oVALID !== 1'b0) begin errors++; $display("[TB] FAIL early_valid got %b want 0", oVALID); end
      feed(8'h80, 0);
      checks++; if (oVALID !== 1'b1) begin errors++; $display("[TB] FAIL unsigned_valid_latency got %b want 1", oVALID); end
      checks++; if (oREADY !== 1'b0) begin errors++; $display("[TB] FAIL done_ready got %b want 0", oREADY); end
      checks++; if (oMAX !== 8'hF0) begin errors++; $display("[TB] FAIL unsigned_max got %h want f0", oMAX); end
      checks++; if (oIDX !== 2'd1) begin errors++; $display("[TB] FAIL unsigned_idx got %0d want 1", oIDX); end
      iACK = 1'b1;
      tick();
      iACK = 1'b0;
      checks++; if (oVALID !== 1'b0) begin errors++; $display("[TB] FAIL ack_valid got %b want 0", oVALID); end
      checks++; if (oBUSY !== 1'b0) begin errors++; $display("[TB] FAIL ack_busy got %b want 0", oBUSY); end
   endtask

   task automatic test_signed();
      start_frame(1'b1);
      feed(8'h10, 0); feed(8'hF0, 0); feed(8'h7F, 0); feed(8'h80, 0);
      checks++; if (oMAX !== 8'h7F) begin errors++; $display("[TB] FAIL signed_max got %h want 7f", oMAX); end
      checks++; if (oIDX !== 2'd2) begin errors++; $display("[TB] FAIL signed_idx got %0d want 2", oIDX); end
      iACK = 1'b1; tick(); iACK = 1'b0;
      start_frame(1'b1);
      feed(8'h80, 0); feed(8'hFF, 0); feed(8'h81, 0); feed(8'hFE, 0);
      checks++; if (oMAX !== 8'hFF) begin errors++; $display("[TB] FAIL signed_neg_max got %h want ff", oMAX); end
      checks++; if (oIDX !== 2'd1) begin errors++; $display("[TB] FAIL signed_neg_idx got %0d want 1", oIDX); end
      iACK = 1'b1; tick(); iACK = 1'b0;
   endtask

   task automatic test_ties();
      start_frame(1'b0);
      feed(8'h05, 0); feed(8'h09, 0); feed(8'h09, 0); feed(8'h03, 0);
      checks++; if (oMAX !== 8'h09) begin errors++; $display("[TB] FAIL tie_max got %h want 09", oMAX); end
      checks++; if (oIDX !== 2'd1) begin errors++; $display("[TB] FAIL tie_idx got %0d want 1", oIDX); end
      iACK = 1'b1; tick(); iACK = 1'b0;
   endtask

   task automatic test_gaps_handshake();
      start_frame(1'b0);
      feed(8'h22, 2); feed(8'h11, 2); feed(8'h33, 2);
      checks++; if (oVALID !== 1'b0) begin errors++; $display("[TB] FAIL gap_early_valid got %b want 0", oVALID); end
      feed(8'h30, 0);
      checks++; if (oVALID !== 1'b1) begin errors++; $display("[TB] FAIL gap_valid got %b want 1", oVALID); end
      checks++; if (oMAX !== 8'h33) begin errors++; $display("[TB] FAIL gap_max got %h want 33", oMAX); end
      checks++; if (oIDX !== 2'd2) begin errors++; $display("[TB] FAIL gap_idx got %0d want 2", oIDX); end
      for (int c = 0; c < 3; c++) begin
         iVALID = 1'b1;
         iDATA  = 8'hFF;
         tick();
         checks++; if (oVALID !== 1'b1 || oMAX !== 8'h33 || oIDX !== 2'd2) begin
            errors++; $display("[TB] FAIL hold_result got v=%b max=%h idx=%0d want v=1 max=33 idx=2", oVALID, oMAX, oIDX);
         end
      end
      iVALID = 1'b0;
      iACK   = 1'b1;
      tick();
      iACK   = 1'b0;
      checks++; if (oVALID !== 1'b0 || oREADY !== 1'b0 || oBUSY !== 1'b0) begin
         errors++; $display("[TB] FAIL gap_after_ack got v=%b r=%b b=%b want 0 0 0", oVALID, oREADY, oBUSY);
      end
   endtask

   task automatic test_reset_midframe();
      start_frame(1'b0);
      feed(8'h10, 0); feed(8'hF0, 0);
      iRST_N = 1'b0;
      tick();
      iRST_N = 1'b1;
      checks++; if (oREADY !== 1'b0 || oVALID !== 1'b0 || oBUSY !== 1'b0 || oMAX !== 8'h00 || oIDX !== 2'd0) begin
         errors++; $display("[TB] FAIL midframe_reset got r=%b v=%b b=%b max=%h idx=%0d want all 0", oREADY, oVALID, oBUSY, oMAX, oIDX);
      end
      start_frame(1'b0);
      feed(8'h01, 0); feed(8'h02, 0); feed(8'hC0, 0); feed(8'h04, 0);
      checks++; if (oVALID !== 1'b1 || oMAX !== 8'hC0 || oIDX !== 2'd2) begin
         errors++; $display("[TB] FAIL post_reset_frame got v=%b max=%h idx=%0d want v=1 max=c0 idx=2", oVALID, oMAX, oIDX);
      end
      iACK = 1'b1; tick(); iACK = 1'b0;
   endtask

   task automatic test_ignored_inputs();
      start_frame(1'b1);
      iSIGNED = 1'b0;
      feed(8'h10, 0);
      iSTART = 1'b1;
      iACK   = 1'b1;
      feed(8'hF0, 0);
      iSTART = 1'b0;
      iACK   = 1'b0;
      feed(8'h7F, 0);
      checks++; if (oREADY !== 1'b1 || oVALID !== 1'b0 || oBUSY !== 1'b1) begin
         errors++; $display("[TB] FAIL ignored_still_run got r=%b v=%b b=%b want 1 0 1", oREADY, oVALID, oBUSY);
      end
      feed(8'h80, 0);
      checks++; if (oVALID !== 1'b1 || oMAX !== 8'h7F || oIDX !== 2'd2) begin
         errors++; $display("[TB] FAIL ignored_result got v=%b max=%h idx=%0d want v=1 max=7f idx=2", oVALID, oMAX, oIDX);
      end
      // iSTART alongside iACK in DONE must not begin a new frame.
      iACK   = 1'b1;
      iSTART = 1'b1;
      tick();
      iACK   = 1'b0;
      iSTART = 1'b0;
      checks++; if (oBUSY !== 1'b0) begin errors++; $display("[TB] FAIL start_in_done got busy=%b want 0", oBUSY); end
      tick();
      checks++; if (oBUSY !== 1'b0) begin errors++; $display("[TB] FAIL idle_stays got busy=%b want 0", oBUSY); end
   endtask

   task automatic test_random();
      logic            m;
      logic [W-1:0]    exp_max;
      logic [IDXW-1:0] exp_idx;
      int              hold;
      for (int f = 0; f < 30; f++) begin
         m = 1'($urandom);
         for (int i = 0; i < LEN; i++) frame_data[i] = W'($urandom);
         if (f % 5 == 0) frame_data[3] = frame_data[1];
         model(m, exp_max, exp_idx);
         start_frame(m);
         for (int i = 0; i < LEN; i++) begin
            feed(frame_data[i], (i < LEN - 1) ? int'($urandom_range(0, 2)) : 0);
         end
         hold = int'($urandom_range(0, 2));
         for (int c = 0; c <= hold; c++) begin
            checks++; if (oVALID !== 1'b1 || oMAX !== exp_max || oIDX !== exp_idx) begin
               errors++; $display("[TB] FAIL random_frame%0d got v=%b max=%h idx=%0d want v=1 max=%h idx=%0d",
                                  f, oVALID, oMAX, oIDX, exp_max, exp_idx);
            end
            if (c == hold) iACK = 1'b1;
            tick();
         end
         iACK = 1'b0;
         checks++; if (oVALID !== 1'b0) begin errors++; $display("[TB] FAIL random_ack%0d got v=%b want 0", f, oVALID); end
      end
   endtask

   initial begin
      iRST_N  = 1'b0;
      iSTART  = 1'b0;
      iSIGNED = 1'b0;
      iDATA   = '0;
      iVALID  = 1'b0;
      iACK    = 1'b0;
      test_reset();
      test_unsigned();
      test_signed();
      test_ties();
      test_gaps_handshake();
      test_reset_midframe();
      test_ignored_inputs();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
